// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle arithmetic, logic, shift and
// rotate operations, plus multi-cycle unsigned multiply (shift-add) and
// unsigned divide (restoring). Each multi-cycle operation takes WIDTH cycles.
//
// Ports:
//   Clk       - system clock; all state changes on the rising edge
//   Reset_n   - asynchronous active-low reset
//   Enable    - block enable; 0 blocks acceptance of new operations
//   InValid   - operation request
//   InReady   - high when an operation can be accepted (state IDLE)
//   Mode      - 5-bit operation select
//   Operand1  - first operand; also the shift/rotate amount (low SHW bits)
//   Operand2  - second operand; the shift/rotate source
//   OutValid  - one-cycle pulse when Result/ResultHi/Flags are updated
//   Result    - primary result, product low half, or quotient
//   ResultHi  - product high half (MUL), remainder (DIV), otherwise 0
//   Flags     - {Z, C, N, V}
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Enable,
  input  logic             InValid,
  output logic             InReady,
  input  logic [4:0]       Mode,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic             OutValid,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic [3:0]       Flags
);

  localparam int CW  = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  localparam logic [4:0] MODE_ADD   = 5'h00;
  localparam logic [4:0] MODE_SUB   = 5'h01;
  localparam logic [4:0] MODE_PASS1 = 5'h02;
  localparam logic [4:0] MODE_PASS2 = 5'h03;
  localparam logic [4:0] MODE_AND   = 5'h04;
  localparam logic [4:0] MODE_OR    = 5'h05;
  localparam logic [4:0] MODE_XOR   = 5'h06;
  localparam logic [4:0] MODE_SUBR  = 5'h07;
  localparam logic [4:0] MODE_INC   = 5'h08;
  localparam logic [4:0] MODE_DEC   = 5'h09;
  localparam logic [4:0] MODE_ROL   = 5'h0A;
  localparam logic [4:0] MODE_ROR   = 5'h0B;
  localparam logic [4:0] MODE_SLL   = 5'h0C;
  localparam logic [4:0] MODE_SRL   = 5'h0D;
  localparam logic [4:0] MODE_SRA   = 5'h0E;
  localparam logic [4:0] MODE_NEG   = 5'h0F;
  localparam logic [4:0] MODE_MUL   = 5'h10;
  localparam logic [4:0] MODE_DIV   = 5'h11;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  // Bit order matches the Flags port: [3] Z, [2] C, [1] N, [0] V.
  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } flags_t;

  // Registered state
  state_e           state_q,     state_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] acc_q,       acc_d;       // partial product high / partial remainder
  logic [WIDTH-1:0] lo_q,        lo_d;        // multiplier bits / dividend-quotient bits
  logic [WIDTH-1:0] opd_q,       opd_d;       // multiplicand / divisor
  logic             is_div_q,    is_div_d;
  logic             dz_q,        dz_d;        // divide-by-zero seen at acceptance
  logic [WIDTH-1:0] result_q,    result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  flags_t           flags_q,     flags_d;
  logic             out_valid_q, out_valid_d;

  logic accept;
  assign InReady = (state_q == ST_IDLE);
  assign accept  = Enable && InValid && InReady;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  // One shared adder/subtractor serves ADD, SUB, SUBR, INC, DEC and NEG.
  // In the WIDTH+1 bit sum, bit WIDTH is the carry for adds and the borrow
  // for subtracts (x - y wraps with the top bit set exactly when x < y).
  logic [WIDTH-1:0]   ar_x, ar_y;
  logic               ar_sub, ar_used;
  logic [WIDTH:0]     ar_sum;
  logic [SHW-1:0]     sh_amt;
  int unsigned        rot_amt;
  logic [2*WIDTH-1:0] rot_wide, rot_l, rot_r;
  logic [WIDTH-1:0]   sc_res;
  flags_t             sc_flags;

  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    ar_x    = Operand1;
    ar_y    = Operand2;
    ar_sub  = 1'b0;
    ar_used = 1'b0;
    unique case (Mode)
      MODE_ADD:  ar_used = 1'b1;
      MODE_SUB:  begin ar_used = 1'b1; ar_sub = 1'b1; end
      MODE_SUBR: begin ar_used = 1'b1; ar_sub = 1'b1; ar_x = Operand2; ar_y = Operand1; end
      MODE_INC:  begin ar_used = 1'b1; ar_y = ONE; end
      MODE_DEC:  begin ar_used = 1'b1; ar_sub = 1'b1; ar_y = ONE; end
      MODE_NEG:  begin ar_used = 1'b1; ar_sub = 1'b1; ar_x = '0; ar_y = Operand1; end
      default:   ;
    endcase
  end

  assign ar_sum = ar_sub ? ({1'b0, ar_x} - {1'b0, ar_y})
                         : ({1'b0, ar_x} + {1'b0, ar_y});

  // Rotates shift a doubled copy of the operand; the amount is reduced
  // modulo WIDTH so that non-power-of-two widths still rotate correctly.
  assign sh_amt   = Operand1[SHW-1:0];
  assign rot_amt  = 32'(sh_amt) % 32'(WIDTH);
  assign rot_wide = {Operand2, Operand2};
  assign rot_l    = rot_wide << rot_amt;
  assign rot_r    = rot_wide >> rot_amt;

  always_comb begin
    sc_res   = Operand2;
    sc_flags = flags_q;
    unique case (Mode)
      MODE_ADD, MODE_SUB, MODE_SUBR,
      MODE_INC, MODE_DEC, MODE_NEG: sc_res = ar_sum[MSB:0];
      MODE_PASS1: sc_res = Operand1;
      MODE_PASS2: sc_res = Operand2;
      MODE_AND:   sc_res = Operand1 & Operand2;
      MODE_OR:    sc_res = Operand1 | Operand2;
      MODE_XOR:   sc_res = Operand1 ^ Operand2;
      MODE_ROL:   sc_res = rot_l[2*WIDTH-1:WIDTH];
      MODE_ROR:   sc_res = rot_r[MSB:0];
      MODE_SLL:   sc_res = Operand2 << sh_amt;
      MODE_SRL:   sc_res = Operand2 >> sh_amt;
      MODE_SRA:   sc_res = $unsigned($signed(Operand2) >>> sh_amt);
      default:    sc_res = Operand2;   // 0x12-0x1F alias PASS2
    endcase
    sc_flags.n = sc_res[MSB];
    sc_flags.z = (sc_res == '0);
    // C and V only move for arithmetic modes; everything else keeps them.
    if (ar_used) begin
      sc_flags.c = ar_sum[WIDTH];
      // Add overflows when the operand MSBs match; subtract when they differ.
      // In both cases the result MSB must differ from the first operand's.
      sc_flags.v = ((ar_x[MSB] ^ ar_y[MSB]) == ar_sub) && (sc_res[MSB] != ar_x[MSB]);
    end
  end

  // ---------------------------------------------------------------------------
  // Multi-cycle iteration step
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] acc_step, lo_step;

  // Shift-add: add the multiplicand when the current multiplier bit is set,
  // then shift the {acc, lo} pair right; product bits fill lo from the top.
  assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
  // Restoring division: shift the next dividend bit into the remainder and
  // try subtracting the divisor; a clear top bit means the subtraction fits.
  // A zero divisor always fits, so the quotient saturates to all ones and the
  // remainder ends up holding the dividend.
  assign div_trial = {acc_q, lo_q[MSB]} - {1'b0, opd_q};

  always_comb begin
    if (is_div_q) begin
      if (!div_trial[WIDTH]) begin
        acc_step = div_trial[MSB:0];
        lo_step  = {lo_q[MSB-1:0], 1'b1};
      end else begin
        acc_step = {acc_q[MSB-1:0], lo_q[MSB]};
        lo_step  = {lo_q[MSB-1:0], 1'b0};
      end
    end else begin
      acc_step = mul_sum[WIDTH:1];
      lo_step  = {mul_sum[0], lo_q[MSB:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    lo_d        = lo_q;
    opd_d       = opd_q;
    is_div_d    = is_div_q;
    dz_d        = dz_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    out_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (Mode == MODE_MUL || Mode == MODE_DIV) begin
            state_d  = ST_BUSY;
            cnt_d    = CW'(WIDTH);
            acc_d    = '0;
            lo_d     = Operand1;
            opd_d    = Operand2;
            is_div_d = (Mode == MODE_DIV);
            dz_d     = (Operand2 == '0);
          end else begin
            result_d    = sc_res;
            result_hi_d = '0;
            flags_d     = sc_flags;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        // Enable is deliberately ignored here: a running op always completes.
        acc_d = acc_step;
        lo_d  = lo_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = ST_IDLE;
          result_d    = lo_step;
          result_hi_d = acc_step;
          out_valid_d = 1'b1;
          flags_d.n   = lo_step[MSB];
          flags_d.z   = (lo_step == '0);
          if (is_div_q) begin
            flags_d.c = 1'b0;
            flags_d.v = dz_q;
          end else begin
            flags_d.c = (acc_step != '0);
            flags_d.v = (acc_step != '0);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      opd_q       <= '0;
      is_div_q    <= 1'b0;
      dz_q        <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its pre-edge value regardless of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      lo_q        <= lo_d;
      opd_q       <= opd_d;
      is_div_q    <= is_div_d;
      dz_q        <= dz_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign OutValid = out_valid_q;
  assign Result   = result_q;
  assign ResultHi = result_hi_q;
  assign Flags    = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq (WIDTH = 8). Stimulus pushes
// hand-computed expected responses into a scoreboard queue; a monitor pops
// and compares on every OutValid pulse. Expected flags are written as
// {Z, C, N, V}.
module tb_alu_seq;

  localparam int W = 8;

  localparam logic [4:0] ADD   = 5'h00, SUB  = 5'h01, PASS1 = 5'h02, PASS2 = 5'h03;
  localparam logic [4:0] AND_  = 5'h04, OR_  = 5'h05, XOR_  = 5'h06, SUBR  = 5'h07;
  localparam logic [4:0] INC   = 5'h08, DEC  = 5'h09, ROL   = 5'h0A, ROR   = 5'h0B;
  localparam logic [4:0] SLL   = 5'h0C, SRL  = 5'h0D, SRA   = 5'h0E, NEG   = 5'h0F;
  localparam logic [4:0] MUL   = 5'h10, DIV  = 5'h11;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         Enable;
  logic         InValid;
  logic         InReady;
  logic [4:0]   Mode;
  logic [W-1:0] Operand1;
  logic [W-1:0] Operand2;
  logic         OutValid;
  logic [W-1:0] Result;
  logic [W-1:0] ResultHi;
  logic [3:0]   Flags;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [3:0]   flags;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  alu_seq #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Enable   (Enable),
    .InValid  (InValid),
    .InReady  (InReady),
    .Mode     (Mode),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .OutValid (OutValid),
    .Result   (Result),
    .ResultHi (ResultHi),
    .Flags    (Flags)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge Clk) begin
    if (Reset_n === 1'b1 && OutValid === 1'b1) begin
      check("pulse_has_pending_op", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_result"}, 32'(Result),   32'(mon_e.res));
        check({mon_e.name, "_hi"},     32'(ResultHi), 32'(mon_e.hi));
        check({mon_e.name, "_flags"},  32'(Flags),    32'(mon_e.flags));
      end
    end
  end

  // Drive one request and wait past the edge that may accept it.
  // InValid is left high so consecutive calls give back-to-back issue.
  task automatic send(input logic [4:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit push, input logic [W-1:0] er, input logic [W-1:0] eh,
                      input logic [3:0] ef, input string name);
    exp_t e;
    if (push) begin
      e.res = er; e.hi = eh; e.flags = ef; e.name = name;
      sb.push_back(e);
    end
    Enable   = 1'b1;
    InValid  = 1'b1;
    Mode     = m;
    Operand1 = a;
    Operand2 = b;
    @(posedge Clk);
    #1;
  endtask

  // Count edges from acceptance until OutValid appears (bounded).
  task automatic wait_out(input string name, input int exp_cycles);
    int n = 0;
    while (OutValid !== 1'b1 && n < 40) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n  = 1'b0;
    Enable   = 1'b0;
    InValid  = 1'b0;
    Mode     = '0;
    Operand1 = '0;
    Operand2 = '0;
    repeat (2) @(negedge Clk);

    // Reset state
    check("reset_result",   32'(Result),   32'h0);
    check("reset_hi",       32'(ResultHi), 32'h0);
    check("reset_flags",    32'(Flags),    32'h0);
    check("reset_outvalid", 32'(OutValid), 32'h0);
    check("reset_inready",  32'(InReady),  32'h1);
    Reset_n = 1'b1;
    @(negedge Clk);

    // ADD with signed overflow; OutValid exactly one cycle after acceptance
    send(ADD, 8'h7F, 8'h01, 1, 8'h80, 8'h00, 4'h3, "add_7f_01");
    check("add_outvalid_next", 32'(OutValid), 32'h1);
    InValid = 1'b0;
    @(posedge Clk); #1;
    check("add_pulse_width", 32'(OutValid), 32'h0);

    // Back-to-back SUBs: zero result, then borrow
    send(SUB, 8'h05, 8'h05, 1, 8'h00, 8'h00, 4'h8, "sub_05_05");
    check("sub1_outvalid", 32'(OutValid), 32'h1);
    send(SUB, 8'h00, 8'h01, 1, 8'hFF, 8'h00, 4'h6, "sub_00_01");
    check("sub2_outvalid", 32'(OutValid), 32'h1);

    // Logic/shift modes keep C=1,V=0 from the borrow above
    send(AND_,  8'hF0, 8'h0F, 1, 8'h00, 8'h00, 4'hC, "and_f0_0f");
    send(ROL,   8'h01, 8'h81, 1, 8'h03, 8'h00, 4'h4, "rol_81_1");
    send(SRA,   8'h03, 8'h80, 1, 8'hF0, 8'h00, 4'h6, "sra_80_3");
    send(ROR,   8'h08, 8'hA5, 1, 8'hA5, 8'h00, 4'h6, "ror_a5_0");
    send(ROR,   8'h04, 8'h12, 1, 8'h21, 8'h00, 4'h4, "ror_12_4");
    send(SLL,   8'h02, 8'h81, 1, 8'h04, 8'h00, 4'h4, "sll_81_2");
    send(SRL,   8'h07, 8'h80, 1, 8'h01, 8'h00, 4'h4, "srl_80_7");
    // Remaining arithmetic modes
    send(SUBR,  8'h10, 8'h30, 1, 8'h20, 8'h00, 4'h0, "subr_30_10");
    send(NEG,   8'h80, 8'h00, 1, 8'h80, 8'h00, 4'h7, "neg_80");
    send(INC,   8'hFF, 8'h00, 1, 8'h00, 8'h00, 4'hC, "inc_ff");
    send(DEC,   8'h80, 8'h00, 1, 8'h7F, 8'h00, 4'h1, "dec_80");
    // Logic and pass modes keep C=0,V=1 from DEC
    send(XOR_,  8'hFF, 8'h0F, 1, 8'hF0, 8'h00, 4'h3, "xor_ff_0f");
    send(OR_,   8'h0C, 8'h30, 1, 8'h3C, 8'h00, 4'h1, "or_0c_30");
    send(PASS1, 8'h00, 8'h55, 1, 8'h00, 8'h00, 4'h9, "pass1_00");
    send(PASS2, 8'h55, 8'h81, 1, 8'h81, 8'h00, 4'h3, "pass2_81");
    send(5'h15, 8'h55, 8'h42, 1, 8'h42, 8'h00, 4'h1, "alias15_42");
    InValid = 1'b0;
    @(posedge Clk); #1;

    // MUL: busy for 8 cycles, ignores requests, operand changes and Enable
    send(MUL, 8'h0F, 8'h11, 1, 8'hFF, 8'h00, 4'h2, "mul_0f_11");
    Mode     = ADD;
    Operand1 = 8'h01;
    Operand2 = 8'h01;
    for (int i = 0; i < 8; i++) begin
      check("mul_busy_inready",  32'(InReady),  32'h0);
      check("mul_busy_outvalid", 32'(OutValid), 32'h0);
      Enable = (i % 2 == 0) ? 1'b0 : 1'b1;
      if (i == 7) begin
        InValid = 1'b0;
        Enable  = 1'b1;
      end
      @(posedge Clk); #1;
    end
    check("mul_done_outvalid", 32'(OutValid), 32'h1);
    check("mul_done_inready",  32'(InReady),  32'h1);

    send(MUL, 8'hFF, 8'hFF, 1, 8'h01, 8'hFE, 4'h5, "mul_ff_ff");
    InValid = 1'b0;
    wait_out("mul_ff_ff", 8);

    send(DIV, 8'd100, 8'd7, 1, 8'h0E, 8'h02, 4'h0, "div_100_7");
    InValid = 1'b0;
    wait_out("div_100_7", 8);

    send(DIV, 8'h2A, 8'h00, 1, 8'hFF, 8'h2A, 4'h3, "div_2a_0");
    InValid = 1'b0;
    wait_out("div_2a_0", 8);
    @(posedge Clk); #1;

    // Reset during MUL iteration 4: op abandoned, outputs clear at once
    send(MUL, 8'h0F, 8'h11, 0, 8'h00, 8'h00, 4'h0, "mul_abort");
    InValid = 1'b0;
    repeat (4) @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("abort_result",   32'(Result),   32'h0);
    check("abort_hi",       32'(ResultHi), 32'h0);
    check("abort_flags",    32'(Flags),    32'h0);
    check("abort_outvalid", 32'(OutValid), 32'h0);
    check("abort_inready",  32'(InReady),  32'h1);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    check("release_inready", 32'(InReady), 32'h1);
    send(ADD, 8'h01, 8'h02, 1, 8'h03, 8'h00, 4'h0, "add_after_reset");
    check("release_accept", 32'(OutValid), 32'h1);
    InValid = 1'b0;

    // Any leftover entry means an op never produced its pulse
    repeat (12) @(posedge Clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
